pipe_thread_ctrl: RTL and testbench

Barrel-style thread scheduler for the 4-thread, 5-stage pattern-matching pipeline. It owns the per-thread program counters and each cycle picks one eligible thread to fetch, round-robin. It drives `pc_if`/`thread_if` into the IF stage and the common enable for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It also applies branch redirects and done notifications that come back from the MEM stage.

---
 rtl/nids_pipe_pkg.sv | 17 +
 rtl/pipe_thread_ctrl_rr_pick4.sv | 28 ++
 rtl/pipe_thread_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_thread_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nids_pipe_pkg.sv
// Shared types and constants for the NIDS pattern-matching pipeline.
// Thread ids, PC width and the fetch NOP.
package nids_pipe_pkg;

  localparam int THREADS = 4;
  localparam int TID_W   = 2;
  localparam int PC_W    = 9;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } thr_state_e;

endpackage

// File: rtl/pipe_thread_ctrl_rr_pick4.sv
// Rotating-priority picker over four threads.
// Search starts at last+1; sel falls back to last+1 when none found.
module rr_pick4
  import nids_pipe_pkg::*;
(
  input  logic [THREADS-1:0] elig,
  input  logic [TID_W-1:0]   last,
  output logic [TID_W-1:0]   sel,
  output logic               found
);

  logic [TID_W-1:0] idx;

  // first eligible thread walking forward from last+1
  always_comb begin
    found = 1'b0;
    sel   = last + TID_W'(1);
    idx   = '0;
    for (int i = 1; i <= THREADS; i++) begin
      idx = last + TID_W'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

endmodule

// File: rtl/pipe_thread_ctrl.sv
// Barrel thread scheduler: per-thread PCs, gap counters and
// round-robin fetch selection with MEM-stage redirect/done.
module pipe_thread_ctrl
  import nids_pipe_pkg::*;
#(
  parameter int ISSUE_GAP = 4,
  parameter int PC_BASE   = 0,
  parameter int PC_STRIDE = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [THREADS-1:0] start_mask,
  input  logic               stall,
  input  logic               branch_taken_mem,
  input  logic [TID_W-1:0]   thread_mem,
  input  logic [PC_W-1:0]    alu_pc_mem,
  input  logic               processing_done_mem,
  output logic [PC_W-1:0]    pc_if,
  output logic [TID_W-1:0]   thread_if,
  output logic               issue_valid,
  output logic               stage_en,
  output logic [THREADS-1:0] thread_busy,
  output logic               all_done
);

  localparam int CNT_W = $clog2(ISSUE_GAP);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'(ISSUE_GAP - 1);

  function automatic logic [PC_W-1:0] start_pc(
    input int t
  );
    int v;
    v = PC_BASE + t * PC_STRIDE;
    return v[PC_W-1:0];
  endfunction

  thr_state_e         st  [THREADS];
  logic [PC_W-1:0]    pc  [THREADS];
  logic [CNT_W-1:0]   cnt [THREADS];
  logic [TID_W-1:0]   last;
  logic [TID_W-1:0]   sel;
  logic               found;
  logic               done_seen;
  logic               do_issue;
  logic [THREADS-1:0] elig;
  logic [THREADS-1:0] busy;
  logic [THREADS-1:0] launch;
  logic [THREADS-1:0] hit;
  logic [THREADS-1:0] iss;

  // per-thread eligibility and edge qualifiers
  always_comb begin
    elig   = '0;
    busy   = '0;
    launch = '0;
    hit    = '0;
    iss    = '0;
    for (int t = 0; t < THREADS; t++) begin
      busy[t]   = (st[t] == RUN);
      elig[t]   = busy[t] && (cnt[t] == '0);
      launch[t] = start && start_mask[t] && !busy[t];
      hit[t]    = (thread_mem == TID_W'(t));
      iss[t]    = do_issue && (sel == TID_W'(t));
    end
  end

  rr_pick4 u_pick (
    .elig  (elig),
    .last  (last),
    .sel   (sel),
    .found (found)
  );

  assign do_issue    = found && !stall;
  assign issue_valid = found;
  assign thread_if   = sel;
  assign pc_if       = pc[sel];
  assign stage_en    = ~stall;
  assign thread_busy = busy;
  assign all_done    = done_seen && (busy == '0);

  // thread state, PCs, gap counters and rotation pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last      <= '1;
      done_seen <= 1'b0;
      for (int t = 0; t < THREADS; t++) begin
        st[t]  <= IDLE;
        pc[t]  <= start_pc(t);
        cnt[t] <= '0;
      end
    end else begin
      if (start)
        done_seen <= 1'b0;
      else if (processing_done_mem)
        done_seen <= 1'b1;
      if (do_issue)
        last <= sel;
      for (int t = 0; t < THREADS; t++) begin
        if (launch[t]) begin
          st[t]  <= RUN;
          pc[t]  <= start_pc(t);
          cnt[t] <= '0;
        end else begin
          if (processing_done_mem && hit[t] && busy[t])
            st[t] <= DONE;
          if (!(processing_done_mem && hit[t])) begin
            if (branch_taken_mem && hit[t])
              pc[t] <= alu_pc_mem;
            else if (iss[t])
              pc[t] <= pc[t] + PC_W'(1);
          end
          if (iss[t])
            cnt[t] <= GAP_LD;
          else if (!stall && cnt[t] != '0)
            cnt[t] <= cnt[t] - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_thread_ctrl.sv
// Directed bench for pipe_thread_ctrl.
// Each task checks one scenario against hand-derived values.
module tb_pipe_thread_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] start_mask;
  logic       stall;
  logic       branch_taken_mem;
  logic [1:0] thread_mem;
  logic [8:0] alu_pc_mem;
  logic       processing_done_mem;
  logic [8:0] pc_if;
  logic [1:0] thread_if;
  logic       issue_valid;
  logic       stage_en;
  logic [3:0] thread_busy;
  logic       all_done;

  int n_run;
  int n_fail;

  pipe_thread_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .start_mask          (start_mask),
    .stall               (stall),
    .branch_taken_mem    (branch_taken_mem),
    .thread_mem          (thread_mem),
    .alu_pc_mem          (alu_pc_mem),
    .processing_done_mem (processing_done_mem),
    .pc_if               (pc_if),
    .thread_if           (thread_if),
    .issue_valid         (issue_valid),
    .stage_en            (stage_en),
    .thread_busy         (thread_busy),
    .all_done            (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [11:0] f(
    input logic v, input int t, input int p
  );
    logic [1:0] tt;
    logic [8:0] pp;
    tt = t[1:0];
    pp = p[8:0];
    return {v, tt, pp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    start_mask = 4'h0;
    stall = 1'b0;
    branch_taken_mem = 1'b0;
    thread_mem = 2'd0;
    alu_pc_mem = 9'd0;
    processing_done_mem = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic launch(input logic [3:0] m);
    start = 1'b1;
    start_mask = m;
    step();
    start = 1'b0;
    start_mask = 4'h0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    step();
    n_run++;
    if ({issue_valid, thread_if, pc_if} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_fetch: got %h want 000",
        {issue_valid, thread_if, pc_if});
    end
    n_run++;
    if ({all_done, thread_busy} !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_status: got %h want 00",
        {all_done, thread_busy});
    end
    stall = 1'b1;
    #1;
    n_run++;
    if (stage_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stage_en: got %b want 0", stage_en);
    end
    stall = 1'b0;
    #1;
    n_run++;
    if (stage_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stage_en1: got %b want 1", stage_en);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_run++;
      if (issue_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_issue: cyc %0d got %b want 0",
          i, issue_valid);
      end
    end
  endtask

  task automatic test_all4();
    logic [11:0] e;
    do_reset();
    launch(4'hf);
    for (int i = 0; i < 8; i++) begin
      e = f(1'b1, i % 4, (i % 4) * 128 + i / 4);
      n_run++;
      if ({issue_valid, thread_if, pc_if} !== e) begin
        n_fail++;
        $display("FAIL all4 cyc %0d: got %h want %h",
          i, {issue_valid, thread_if, pc_if}, e);
      end
      step();
    end
  endtask

  task automatic test_single();
    logic [11:0] e;
    do_reset();
    launch(4'h1);
    for (int i = 0; i < 10; i++) begin
      if (i % 4 == 0) e = f(1'b1, 0, i / 4);
      else            e = f(1'b0, 1, 128);
      n_run++;
      if ({issue_valid, thread_if, pc_if} !== e) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %h want %h",
          i, {issue_valid, thread_if, pc_if}, e);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [11:0] e [4];
    logic [11:0] got [4];
    do_reset();
    launch(4'h2);
    got[0] = {issue_valid, thread_if, pc_if};
    e[0] = f(1'b1, 1, 128);
    branch_taken_mem = 1'b1;
    thread_mem = 2'd1;
    alu_pc_mem = 9'd511;
    step();
    branch_taken_mem = 1'b0;
    got[1] = {issue_valid, thread_if, pc_if};
    e[1] = f(1'b0, 2, 256);
    repeat (3) step();
    got[2] = {issue_valid, thread_if, pc_if};
    e[2] = f(1'b1, 1, 511);
    repeat (4) step();
    got[3] = {issue_valid, thread_if, pc_if};
    e[3] = f(1'b1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if (got[i] !== e[i]) begin
        n_fail++;
        $display("FAIL wrap step %0d: got %h want %h",
          i, got[i], e[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [11:0] e [8];
    e = '{f(1, 0, 0), f(1, 1, 128), f(1, 2, 256), f(1, 3, 384),
          f(1, 0, 1), f(1, 1, 64), f(1, 2, 257), f(1, 3, 385)};
    do_reset();
    launch(4'hf);
    for (int i = 0; i < 8; i++) begin
      n_run++;
      if ({issue_valid, thread_if, pc_if} !== e[i]) begin
        n_fail++;
        $display("FAIL branch cyc %0d: got %h want %h",
          i, {issue_valid, thread_if, pc_if}, e[i]);
      end
      if (i == 1) begin
        branch_taken_mem = 1'b1;
        thread_mem = 2'd1;
        alu_pc_mem = 9'h040;
      end
      step();
      branch_taken_mem = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [11:0] e [6];
    e = '{f(1, 0, 0), f(1, 1, 128), f(1, 2, 256),
          f(1, 3, 384), f(1, 0, 1), f(1, 1, 129)};
    do_reset();
    launch(4'hf);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
          #1;
          n_run++;
          if ({stage_en, issue_valid, thread_if, pc_if} !==
              {1'b0, e[2]}) begin
            n_fail++;
            $display("FAIL stall hold %0d: got %h want %h", s,
              {stage_en, issue_valid, thread_if, pc_if},
              {1'b0, e[2]});
          end
          step();
        end
        stall = 1'b0;
        #1;
      end
      n_run++;
      if ({stage_en, issue_valid, thread_if, pc_if} !==
          {1'b1, e[i]}) begin
        n_fail++;
        $display("FAIL stall seq cyc %0d: got %h want %h", i,
          {stage_en, issue_valid, thread_if, pc_if},
          {1'b1, e[i]});
      end
      step();
    end
  endtask

  task automatic test_done();
    logic [11:0] e [7];
    logic [11:0] x;
    e = '{f(0, 2, 257), f(1, 3, 385), f(1, 0, 2), f(1, 1, 130),
          f(0, 2, 257), f(1, 3, 386), f(1, 0, 3)};
    do_reset();
    launch(4'hf);
    for (int i = 0; i < 6; i++) begin
      x = f(1'b1, i % 4, (i % 4) * 128 + i / 4);
      n_run++;
      if ({issue_valid, thread_if, pc_if} !== x) begin
        n_fail++;
        $display("FAIL done pre cyc %0d: got %h want %h",
          i, {issue_valid, thread_if, pc_if}, x);
      end
      if (i == 5) begin
        processing_done_mem = 1'b1;
        thread_mem = 2'd2;
      end
      step();
      processing_done_mem = 1'b0;
    end
    n_run++;
    if ({all_done, thread_busy} !== 5'b0_1011) begin
      n_fail++;
      $display("FAIL done busy: got %b want 01011",
        {all_done, thread_busy});
    end
    for (int i = 0; i < 7; i++) begin
      n_run++;
      if ({issue_valid, thread_if, pc_if} !== e[i]) begin
        n_fail++;
        $display("FAIL done post cyc %0d: got %h want %h",
          i + 6, {issue_valid, thread_if, pc_if}, e[i]);
      end
      step();
    end
    processing_done_mem = 1'b1;
    thread_mem = 2'd0;
    step();
    thread_mem = 2'd1;
    step();
    processing_done_mem = 1'b0;
    n_run++;
    if ({all_done, thread_busy} !== 5'b0_1000) begin
      n_fail++;
      $display("FAIL done partial: got %b want 01000",
        {all_done, thread_busy});
    end
    processing_done_mem = 1'b1;
    thread_mem = 2'd3;
    step();
    processing_done_mem = 1'b0;
    n_run++;
    if ({all_done, thread_busy, issue_valid} !== 6'b1_0000_0) begin
      n_fail++;
      $display("FAIL all_done: got %b want 100000",
        {all_done, thread_busy, issue_valid});
    end
    launch(4'hf);
    n_run++;
    if ({all_done, thread_busy, issue_valid} !== 6'b0_1111_1) begin
      n_fail++;
      $display("FAIL restart: got %b want 011111",
        {all_done, thread_busy, issue_valid});
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    test_reset();
    test_all4();
    test_single();
    test_wrap();
    test_branch();
    test_stall();
    test_done();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
